// File: rtl/canny_hysteresis.sv
// canny_hysteresis: double-threshold hysteresis stage of the Canny pipeline.
// Consumes a 3x3 window of NMS magnitudes per beat. It emits an all-ones edge pixel when:
//   - the centre is strong, or
//   - the centre is weak and at least one of its 8 neighbours is strong.
// Pixels on the frame border, or flagged by data_valid, are forced to 0.
// Latency is two cycles from an accepted beat to edge_valid.
// Optional feature: define HYST_STAT_EN to count edges per completed frame on edge_count.
//   When HYST_STAT_EN is undefined, edge_count is tied to 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start&en_fun; th_load updates shadow thresholds
// S_RUN   | accepting window beats, col/row tracking frame position
// S_FLUSH | two cycles letting the 2-stage pipeline drain, no new beats
// S_DONE  | one cycle, frame_done high, statistics published
module canny_hysteresis #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 640,
  parameter int DEPTH      = 506,
  parameter int DEF_HIGH   = 80,
  parameter int DEF_LOW    = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_fun,
  input  logic                  start,
  input  logic                  matrix_clken,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
  input  logic                  th_load,
  input  logic [DATA_WIDTH-1:0] th_high,
  input  logic [DATA_WIDTH-1:0] th_low,
  output logic [DATA_WIDTH-1:0] edge_pix,
  output logic                  edge_valid,
  output logic                  frame_done,
  output logic                  busy,
  output logic [19:0]           edge_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] DEF_HI = DATA_WIDTH'(DEF_HIGH);
  localparam logic [DATA_WIDTH-1:0] DEF_LO = DATA_WIDTH'(DEF_LOW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    flush_cnt;
  logic                    wait_low;
  logic [DATA_WIDTH-1:0]   sh_high, sh_low;
  logic [DATA_WIDTH-1:0]   act_high, act_low;

  logic [8:0][DATA_WIDTH-1:0] taps;
  logic [8:0]              strong_now;
  logic                    weak22_now;
  logic                    border_now;
  logic                    run_entry, abort, accept, done_entry;

  logic                    s1_valid;
  logic [8:0]              s1_strong;
  logic                    s1_weak22;
  logic                    s1_border;
  logic                    edge_bit;

  assign taps = {matrix_p33, matrix_p32, matrix_p31,
                 matrix_p23, matrix_p22, matrix_p21,
                 matrix_p13, matrix_p12, matrix_p11};

  // wait_low blocks re-triggering a frame while start is still held from the last one
  assign run_entry  = (state == S_IDLE) && start && en_fun && !wait_low;
  assign abort      = ((state == S_RUN) || (state == S_FLUSH)) && !(start && en_fun);
  assign accept     = (state == S_RUN) && matrix_clken && !abort;
  assign done_entry = (state == S_FLUSH) && !abort && (flush_cnt == 1'b0);

  // per-tap classification against the thresholds frozen for this frame
  always_comb begin
    strong_now = '0;
    for (int i = 0; i < 9; i++) strong_now[i] = (taps[i] >= act_high);
    weak22_now = (matrix_p22 >= act_low) && (matrix_p22 < act_high);
    border_now = data_valid || (row == '0) || (row == ROW_LAST) ||
                 (col == '0) || (col == COL_LAST);
  end

  assign edge_bit = !s1_border &&
                    (s1_strong[4] || (s1_weak22 && (|{s1_strong[8:5], s1_strong[3:0]})));

  // frame sequencing FSM with threshold shadowing and frame position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      flush_cnt  <= 1'b0;
      wait_low   <= 1'b0;
      sh_high    <= DEF_HI;
      sh_low     <= DEF_LO;
      act_high   <= DEF_HI;
      act_low    <= DEF_LO;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!start) wait_low <= 1'b0;
      case (state)
        S_IDLE: begin
          if (th_load) begin
            sh_high <= th_high;
            sh_low  <= (th_low > th_high) ? th_high : th_low;
          end
          if (run_entry) begin
            state    <= S_RUN;
            act_high <= sh_high;
            act_low  <= sh_low;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row       <= '0;
                state     <= S_FLUSH;
                flush_cnt <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (done_entry) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          wait_low <= start;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // two-stage pixel pipeline; an abort or en_fun low kills anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_strong  <= '0;
      s1_weak22  <= 1'b0;
      s1_border  <= 1'b0;
      edge_pix   <= '0;
      edge_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_strong <= strong_now;
        s1_weak22 <= weak22_now;
        s1_border <= border_now;
      end
      if (abort || !en_fun) begin
        edge_valid <= 1'b0;
      end else begin
        edge_valid <= s1_valid;
        if (s1_valid) edge_pix <= {DATA_WIDTH{edge_bit}};
      end
    end
  end

`ifdef HYST_STAT_EN
  logic [19:0] stat_cnt;
  logic        edge_inc;

  assign edge_inc = s1_valid && !abort && en_fun && edge_bit;

  // saturating per-frame edge counter, published when the frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt   <= '0;
      edge_count <= '0;
    end else begin
      if (run_entry) stat_cnt <= '0;
      else if (edge_inc && (stat_cnt != 20'hFFFFF)) stat_cnt <= stat_cnt + 20'd1;
      if (done_entry) edge_count <= stat_cnt;
    end
  end
`else
  assign edge_count = '0;
`endif

endmodule

// File: tb/tb_canny_hysteresis.sv
// Self-checking bench for canny_hysteresis on a small 8x4 frame.
module tb_canny_hysteresis;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NB = W * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_fun = 1'b0, start = 1'b0, matrix_clken = 1'b0, data_valid = 1'b0;
  logic [8:0][DW-1:0] t = '0;
  logic th_load = 1'b0;
  logic [DW-1:0] th_high = '0, th_low = '0;
  logic [DW-1:0] edge_pix;
  logic edge_valid, frame_done, busy;
  logic [19:0] edge_count;

  canny_hysteresis #(.DATA_WIDTH(DW), .WIDTH(W), .DEPTH(D), .DEF_HIGH(80), .DEF_LOW(40)) dut (
    .clk(clk), .rst_n(rst_n), .en_fun(en_fun), .start(start),
    .matrix_clken(matrix_clken), .data_valid(data_valid),
    .matrix_p11(t[0]), .matrix_p12(t[1]), .matrix_p13(t[2]),
    .matrix_p21(t[3]), .matrix_p22(t[4]), .matrix_p23(t[5]),
    .matrix_p31(t[6]), .matrix_p32(t[7]), .matrix_p33(t[8]),
    .th_load(th_load), .th_high(th_high), .th_low(th_low),
    .edge_pix(edge_pix), .edge_valid(edge_valid), .frame_done(frame_done),
    .busy(busy), .edge_count(edge_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int m_hi = 80, m_lo = 40;
  int model_edges = 0, ev_count = 0;
  int exp_done_cyc = -10;
  bit mon_en = 1'b0;

  typedef struct { int due; bit pix; } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit                 load;
    int                 hi;
    int                 lo;
    logic [8:0][DW-1:0] taps;
    bit                 exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0][DW-1:0] fill(input int c, input int o, input int idx, input int v);
    logic [8:0][DW-1:0] r;
    for (int i = 0; i < 9; i++) r[i] = DW'(o);
    r[idx] = DW'(v);
    r[4]   = DW'(c);
    return r;
  endfunction

  // hysteresis rule straight from the definition of strong/weak pixels
  function automatic bit ref_edge(input logic [8:0][DW-1:0] tp, input int hi, input int lo, input bit border);
    if (border) return 1'b0;
    if (int'(tp[4]) >= hi) return 1'b1;
    if (int'(tp[4]) >= lo)
      for (int i = 0; i < 9; i++)
        if (i != 4 && int'(tp[i]) >= hi) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_th(input int h, input int l);
    th_high = DW'(h); th_low = DW'(l); th_load = 1'b1;
    tick();
    th_load = 1'b0;
    m_hi = h;
    m_lo = (l > h) ? h : l;
  endtask

  // cycle-by-cycle monitor: edge_valid/edge_pix timing, frame_done pulse, busy after done
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("edge_valid", 32'(edge_valid), 32'd1);
        check("edge_pix", 32'(edge_pix), exp_q[0].pix ? 32'hFFFF : 32'h0);
        void'(exp_q.pop_front());
      end else begin
        check("edge_valid_idle", 32'(edge_valid), 32'd0);
      end
      check("frame_done", 32'(frame_done), 32'(cyc == exp_done_cyc));
      if (cyc == exp_done_cyc + 1) check("busy_after_done", 32'(busy), 32'd0);
      if (edge_valid) ev_count++;
    end
  end

  // mode 0: fixed taps, table expectation; mode 1: fixed taps, model; mode 2: random, model
  task automatic run_frame(input int mode, input int gap, input logic [8:0][DW-1:0] ft, input bit fexp);
    int  last;
    bit  border, e;
    int  ng;
    mon_en = 1'b1; ev_count = 0; model_edges = 0; exp_done_cyc = -10;
    start = 1'b1; en_fun = 1'b1;
    tick();
    last = 0;
    for (int k = 0; k < NB; k++) begin
      data_valid = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (mode == 2)
        for (int i = 0; i < 9; i++) t[i] = DW'($urandom_range(0, 127));
      else
        t = ft;
      border = data_valid || (k / W == 0) || (k / W == D - 1) || (k % W == 0) || (k % W == W - 1);
      e = (mode == 0) ? (fexp && !border) : ref_edge(t, m_hi, m_lo, border);
      if (e) model_edges++;
      matrix_clken = 1'b1;
      exp_q.push_back('{due: cyc + 2, pix: e});
      last = cyc;
      tick();
      ng = (mode == 2) ? int'($urandom_range(0, gap)) : gap;
      if (k != NB - 1)
        for (int g = 0; g < ng; g++) begin
          matrix_clken = 1'b0;
          t[4] = DW'($urandom);
          tick();
        end
    end
    matrix_clken = 1'b0;
    data_valid = 1'b0;
    exp_done_cyc = last + 3;
    for (int g = 0; g < 10 && cyc <= exp_done_cyc + 1; g++) tick();
    check("beats_emitted", 32'(ev_count), 32'(NB));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef HYST_STAT_EN
    check("edge_count", 32'(edge_count), 32'(model_edges));
`else
    check("edge_count", 32'(edge_count), 32'd0);
`endif
    // start still high: the block must not retrigger
    repeat (2) begin
      @(negedge clk);
      check("no_retrigger", 32'(busy), 32'd0);
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    int fd;
    vecs[0] = '{0, 80, 40, fill(100, 100, 0, 100), 1'b1};
    vecs[1] = '{1, 80, 40, fill(50, 10, 2, 90), 1'b1};
    vecs[2] = '{1, 80, 40, fill(50, 10, 2, 79), 1'b0};
    vecs[3] = '{1, 30, 60, fill(45, 0, 0, 0), 1'b1};
    vecs[4] = '{1, 80, 40, fill(80, 0, 0, 0), 1'b1};
    vecs[5] = '{1, 80, 40, fill(40, 0, 6, 80), 1'b1};
    vecs[6] = '{1, 80, 40, fill(39, 0, 6, 200), 1'b0};
    vecs[7] = '{1, 50, 50, fill(49, 200, 0, 200), 1'b0};
    vecs[8] = '{1, 80, 40, fill(79, 79, 0, 79), 1'b0};
    vecs[9] = '{1, 80, 40, fill(60, 0, 8, 65535), 1'b1};

    repeat (3) tick();
    check("rst_edge_pix", 32'(edge_pix), 32'd0);
    check("rst_edge_valid", 32'(edge_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // table frames; the first uses reset-default thresholds and 3-cycle clken gaps
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].load) load_th(vecs[v].hi, vecs[v].lo);
      run_frame(0, (v == 0) ? 3 : 0, vecs[v].taps, vecs[v].exp);
    end

    // randomized frames against the reference rule
    for (int f = 0; f < 6; f++) begin
      load_th(int'($urandom_range(0, 120)), int'($urandom_range(0, 120)));
      run_frame(2, 2, '0, 1'b0);
    end

    // abort mid-frame with a th_load attempt during RUN
    mon_en = 1'b0; exp_q.delete();
    load_th(80, 40);
    start = 1'b1; en_fun = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      t = fill(100, 100, 0, 100);
      matrix_clken = 1'b1;
      th_load = (k == 5); th_high = 16'd200; th_low = 16'd150;
      tick();
    end
    th_load = 1'b0;
    start = 1'b0; matrix_clken = 1'b0;
    tick();
    @(negedge clk);
    check("abort_edge_valid", 32'(edge_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    fd = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    check("abort_no_frame_done", 32'(fd), 32'd0);
    tick();
    run_frame(1, 0, fill(100, 100, 0, 100), 1'b0);

    // asynchronous reset in the middle of a frame
    mon_en = 1'b0; exp_q.delete();
    load_th(90, 20);
    start = 1'b1; en_fun = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      t = fill(100, 100, 0, 100);
      matrix_clken = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_edge_pix", 32'(edge_pix), 32'd0);
    check("midrst_edge_valid", 32'(edge_valid), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_edge_count", 32'(edge_count), 32'd0);
    start = 1'b0; matrix_clken = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_hi = 80; m_lo = 40;
    tick();
    run_frame(1, 0, fill(85, 0, 0, 0), 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
